// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if
//   Bundles the signals between the PS/2 receive FIFO / display side and the
//   key sequencer ps2_key_ctrl.
//   FIFO side   : kb_data, kb_ready, kb_overflow (into the sequencer),
//                 kb_nextdata_n (active-low pop strobe back to the FIFO).
//   Control     : ovf_clr clears the latched overflow flag.
//   Key status  : key_code, key_ext, key_valid, key_count, byte_hist,
//                 ovf_sticky and the one-cycle press/repeat/release pulses.
//   master : the FIFO + display environment that drives the sequencer.
//   slave  : the sequencer itself (ps2_key_ctrl).
interface ps2_key_ctrl_if;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        kb_overflow;
    logic        ovf_clr;
    logic        kb_nextdata_n;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_valid;
    logic        press_pulse;
    logic        repeat_pulse;
    logic        release_pulse;
    logic [7:0]  key_count;
    logic [23:0] byte_hist;
    logic        ovf_sticky;

    modport master (
        output kb_data,
        output kb_ready,
        output kb_overflow,
        output ovf_clr,
        input  kb_nextdata_n,
        input  key_code,
        input  key_ext,
        input  key_valid,
        input  press_pulse,
        input  repeat_pulse,
        input  release_pulse,
        input  key_count,
        input  byte_hist,
        input  ovf_sticky
    );

    modport slave (
        input  kb_data,
        input  kb_ready,
        input  kb_overflow,
        input  ovf_clr,
        output kb_nextdata_n,
        output key_code,
        output key_ext,
        output key_valid,
        output press_pulse,
        output repeat_pulse,
        output release_pulse,
        output key_count,
        output byte_hist,
        output ovf_sticky
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
//   Pops scan-code bytes from the PS/2 receive FIFO one at a time and parses
//   make / break / E0-extended sequences. Tracks the held key, counts
//   presses, keeps the last three raw bytes for the hex displays and latches
//   FIFO overflow.
//   Ports:
//     clk  : system clock
//     rst  : synchronous, active-high reset
//     kb   : ps2_key_ctrl_if.slave
//            in : kb_data, kb_ready, kb_overflow, ovf_clr
//            out: kb_nextdata_n, key_code, key_ext, key_valid, press_pulse,
//                 repeat_pulse, release_pulse, key_count, byte_hist,
//                 ovf_sticky
//   Parameters:
//     TIMEOUT_CYCLES : idle cycles in a prefix state before falling back to
//                      NORMAL
//     TW             : timeout counter width (TIMEOUT_CYCLES < 2**TW)
module ps2_key_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TW             = 16
) (
    input  logic           clk,
    input  logic           rst,
    ps2_key_ctrl_if.slave  kb
);

    // Handshake FSM
    localparam logic [1:0] HS_IDLE  = 2'd0;
    localparam logic [1:0] HS_POP   = 2'd1;
    localparam logic [1:0] HS_GUARD = 2'd2;

    // Parser FSM
    localparam logic [1:0] PS_NORMAL   = 2'd0;
    localparam logic [1:0] PS_GOT_E0   = 2'd1;
    localparam logic [1:0] PS_GOT_F0   = 2'd2;
    localparam logic [1:0] PS_GOT_E0F0 = 2'd3;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    hs_state;
    logic [1:0]    ps_state;
    logic [TW-1:0] tmo_cnt;

    logic          nextdata_n;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_valid;
    logic          press_pulse;
    logic          repeat_pulse;
    logic          release_pulse;
    logic [7:0]    key_count;
    logic [23:0]   byte_hist;
    logic          ovf_sticky;

    // Byte decode (only acted upon when capture is high)
    logic          capture;
    logic [7:0]    cap_byte;
    logic [1:0]    ps_next;
    logic          byte_ext;
    logic          key_match;
    logic          do_press;
    logic          do_repeat;
    logic          do_release;

    // A byte is taken only from IDLE; POP and GUARD give the FIFO time to
    // drop kb_ready before the head is looked at again.
    assign capture  = (hs_state == HS_IDLE) && kb.kb_ready;
    assign cap_byte = kb.kb_data;

    // Extended flag of the sequence the current byte would complete.
    assign byte_ext  = (ps_state == PS_GOT_E0) || (ps_state == PS_GOT_E0F0);
    assign key_match = key_valid && (cap_byte == key_code) && (byte_ext == key_ext);

    always_comb begin
        ps_next    = ps_state;
        do_press   = 1'b0;
        do_repeat  = 1'b0;
        do_release = 1'b0;
        if ((cap_byte == 8'h00) || (cap_byte == 8'hFF)) begin
            // keyboard error byte: drop any partial sequence
            ps_next = PS_NORMAL;
        end else if (cap_byte == 8'hE0) begin
            // E0 always starts a fresh extended sequence, even mid-break
            ps_next = PS_GOT_E0;
        end else if (cap_byte == 8'hF0) begin
            case (ps_state)
                PS_NORMAL: ps_next = PS_GOT_F0;
                PS_GOT_E0: ps_next = PS_GOT_E0F0;
                default:   ps_next = ps_state;
            endcase
        end else if ((ps_state == PS_NORMAL) || (ps_state == PS_GOT_E0)) begin
            ps_next = PS_NORMAL;
            if (key_match) begin
                do_repeat = 1'b1;
            end else begin
                do_press = 1'b1;
            end
        end else begin
            ps_next = PS_NORMAL;
            // break of anything other than the held key is ignored
            do_release = key_match;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_state      <= HS_IDLE;
            ps_state      <= PS_NORMAL;
            tmo_cnt       <= '0;
            nextdata_n    <= 1'b1;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            key_valid     <= 1'b0;
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            key_count     <= 8'h00;
            byte_hist     <= 24'h000000;
            ovf_sticky    <= 1'b0;
        end else begin
            // Pop handshake: one low cycle per byte, then a guard cycle
            case (hs_state)
                HS_IDLE: begin
                    if (kb.kb_ready) begin
                        nextdata_n <= 1'b0;
                        hs_state   <= HS_POP;
                    end
                end
                HS_POP: begin
                    nextdata_n <= 1'b1;
                    hs_state   <= HS_GUARD;
                end
                HS_GUARD: begin
                    hs_state <= HS_IDLE;
                end
                default: begin
                    nextdata_n <= 1'b1;
                    hs_state   <= HS_IDLE;
                end
            endcase

            // Pulses are high only in the cycle following a capture
            press_pulse   <= capture && do_press;
            repeat_pulse  <= capture && do_repeat;
            release_pulse <= capture && do_release;

            // Set has priority over clear
            if (kb.kb_overflow) begin
                ovf_sticky <= 1'b1;
            end else if (kb.ovf_clr) begin
                ovf_sticky <= 1'b0;
            end

            // Parse / timeout: a capture on the expiry cycle is parsed in
            // the prefix state it arrived in.
            if (capture) begin
                byte_hist <= {byte_hist[15:0], cap_byte};
                ps_state  <= ps_next;
                tmo_cnt   <= '0;
                if (do_press) begin
                    key_code  <= cap_byte;
                    key_ext   <= byte_ext;
                    key_valid <= 1'b1;
                    key_count <= key_count + 8'd1;
                end
                if (do_release) begin
                    key_valid <= 1'b0;
                end
            end else if (ps_state == PS_NORMAL) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                ps_state <= PS_NORMAL;
                tmo_cnt  <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign kb.kb_nextdata_n = nextdata_n;
    assign kb.key_code      = key_code;
    assign kb.key_ext       = key_ext;
    assign kb.key_valid     = key_valid;
    assign kb.press_pulse   = press_pulse;
    assign kb.repeat_pulse  = repeat_pulse;
    assign kb.release_pulse = release_pulse;
    assign kb.key_count     = key_count;
    assign kb.byte_hist     = byte_hist;
    assign kb.ovf_sticky    = ovf_sticky;

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Sequencer between the ps2_keyboard receive FIFO and the display/ASCII logic.
- Pops scan-code bytes with the FIFO's ready/nextdata_n handshake and parses make, break and E0-extended sequences.
- Tracks the currently held key, counts presses, and keeps a 3-byte raw history for the hex displays.
- Replaces the ad-hoc pop logic in the keyboard top level.

Parameters:
- TIMEOUT_CYCLES, 50000: idle cycles in a prefix state before the parser returns to NORMAL.
- TW, 16: width of the timeout counter; TIMEOUT_CYCLES < 2^TW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- kb_data  in  8  FIFO head byte, valid while kb_ready=1
- kb_ready  in  1  FIFO non-empty
- kb_overflow  in  1  FIFO overflow flag
- ovf_clr  in  1  clears ovf_sticky
- kb_nextdata_n  out  1  pop strobe to FIFO, active-low, one cycle per byte
- key_code  out  8  make code of held/last key
- key_ext  out  1  held/last key was E0-prefixed
- key_valid  out  1  a key is currently held
- press_pulse  out  1  one-cycle pulse on new press
- repeat_pulse  out  1  one-cycle pulse on typematic repeat of held key
- release_pulse  out  1  one-cycle pulse on release of held key
- key_count  out  8  number of presses, wraps 255->0
- byte_hist  out  24  last three raw bytes, newest in [7:0]
- ovf_sticky  out  1  latched kb_overflow

Behaviour:
- Reset (rst=1 at posedge) sets:
  - kb_nextdata_n=1.
  - All other outputs 0.
  - Handshake FSM to IDLE, parser to NORMAL, timeout counter to 0.
  - If reset lands mid-pop, kb_nextdata_n is 1 at the next edge.
- Handshake FSM (IDLE, POP, GUARD):
  - IDLE & kb_ready=1: capture kb_data, register kb_nextdata_n=0, go to POP. The parse and the byte_hist shift use the captured byte on this same edge.
  - POP: kb_nextdata_n=1 on the next edge, go to GUARD.
  - GUARD: kb_ready is ignored for one cycle, then return to IDLE.
  - Result: exactly one low cycle per byte and at most one byte per 3 cycles. kb_nextdata_n is never low while kb_ready=0.
- byte_hist <= {byte_hist[15:0], byte} on every capture, including prefixes and error bytes.
- Parser states: NORMAL, GOT_E0, GOT_F0, GOT_E0F0. Per captured byte b:
  - b=0x00 or 0xFF (keyboard error): discard, state <= NORMAL, no pulses.
  - b=0xE0: state <= GOT_E0 from any state. Seeing it in GOT_F0 or GOT_E0F0 is a protocol error; restart.
  - b=0xF0:
    - NORMAL -> GOT_F0.
    - GOT_E0 -> GOT_E0F0.
    - GOT_F0 and GOT_E0F0 hold their state.
  - Other b in NORMAL or GOT_E0 (make), with ext = (state==GOT_E0):
    - If key_valid and b==key_code and ext==key_ext: repeat_pulse=1, nothing else changes.
    - Otherwise: key_code<=b, key_ext<=ext, key_valid<=1, key_count<=key_count+1 (mod 256), press_pulse=1.
    - State <= NORMAL.
  - Other b in GOT_F0 or GOT_E0F0 (break), with ext = (state==GOT_E0F0):
    - If key_valid and b==key_code and ext==key_ext: key_valid<=0, release_pulse=1. key_code and key_ext are retained.
    - Otherwise: ignored, no pulse.
    - State <= NORMAL.
- Pulses are registered, high only on the edge following the capture, and mutually exclusive.
- Timeout:
  - Counter increments each cycle while the parser is in a prefix state and no capture occurs.
  - Counter clears on any capture or when the parser is in NORMAL.
  - Reaching TIMEOUT_CYCLES forces NORMAL and clears the counter; no pulses, key state unchanged.
  - A capture in the same cycle as expiry wins: the byte is parsed in the current prefix state.
- ovf_sticky:
  - Set by kb_overflow=1.
  - Cleared by ovf_clr=1.
  - If both are high, set wins.

Test Plan:
- FIFO presents 0x1C with kb_ready held high:
  - kb_nextdata_n low for exactly 1 cycle, next pop no earlier than 3 cycles later.
  - key_code=0x1C, key_ext=0, key_valid=1, key_count=1, press_pulse for 1 cycle, byte_hist=0x00001C.
- Sequence 1C,1C,F0,1C:
  - One press_pulse, then one repeat_pulse, then one release_pulse.
  - key_count=1, key_valid=0, key_code stays 0x1C, byte_hist=0x1CF01C.
- Sequence E0,75 then E0,F0,75:
  - key_code=0x75, key_ext=1, press then release.
  - Sequence F0,75 (non-extended) while E0 75 is held: no release, key_valid stays 1.
- Hold 0x1C, then send 0x32:
  - New press, key_code=0x32, key_count=2.
  - Then F0,1C: ignored, key_valid=1.
- Send F0, idle TIMEOUT_CYCLES (bench uses 20), then 1C:
  - Parser is back in NORMAL, so 1C is treated as a press (press_pulse, key_count+1).
  - Send 0x00 after E0: discarded, next 75 gives key_ext=0.
- Boundary checks:
  - 256 distinct-alternating presses: key_count wraps to 0.
  - kb_overflow pulse: ovf_sticky=1 until ovf_clr.
  - rst asserted in POP: next cycle kb_nextdata_n=1 and all outputs 0.
